// File: rtl/wb_timer_slave.sv
// -----------------------------------------------------------------------------
// wb_timer_slave
//
// Wishbone slave timer peripheral. It hangs off a free slave port of the
// interconnect and provides a 32-bit up-counter with a prescaler, a compare
// match, optional auto-reload on match, and a level interrupt. irq_o is meant
// for one of the spare CPU interrupt inputs.
//
// Register map (byte address bits [3:2]; all other address bits ignored):
//   0 CTRL    [0] EN, [1] AUTO, [2] IE        (other bits read 0)
//   1 COUNT   32-bit counter, read/write
//   2 COMPARE 32-bit compare value, read/write
//   3 STATUS  [0] PEND, write 1 to clear      (other bits read 0)
//
// Every bus request is acknowledged with a fixed single wait state. wb_ack_o
// is high for exactly the one cycle after the request is sampled. Read data
// is only driven while the ack is high and is 0 otherwise.
//
// Parameters:
//   PRESCALE       enabled clk cycles per counter tick (1..65535)
//   RESET_COMPARE  value loaded into COMPARE at reset
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active low
//   wb_addr_i  byte address, only [3:2] decoded
//   wb_data_i  write data
//   wb_data_o  read data, valid while wb_ack_o = 1
//   wb_we_i    1 = write, 0 = read
//   wb_sel_i   byte lane enables, bit n covers bits [8n+7:8n]
//   wb_stb_i   strobe
//   wb_cyc_i   bus cycle
//   wb_ack_o   transfer acknowledge
//   irq_o      interrupt, level, active high (PEND & IE, registered)
// -----------------------------------------------------------------------------
module wb_timer_slave #(
   parameter int unsigned PRESCALE      = 1,
   parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_addr_i,
   input  logic [31:0] wb_data_i,
   output logic [31:0] wb_data_o,
   input  logic        wb_we_i,
   input  logic [3:0]  wb_sel_i,
   input  logic        wb_stb_i,
   input  logic        wb_cyc_i,
   output logic        wb_ack_o,
   output logic        irq_o
);

   typedef enum logic [1:0] {
      REG_CTRL    = 2'd0,
      REG_COUNT   = 2'd1,
      REG_COMPARE = 2'd2,
      REG_STATUS  = 2'd3
   } reg_addr_e;

   localparam int CTRL_EN   = 0;
   localparam int CTRL_AUTO = 1;
   localparam int CTRL_IE   = 2;

   // Terminal value of the prescaler; a tick is produced when it wraps.
   localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [2:0]  ctrl_q,    ctrl_d;
   logic [31:0] count_q,   count_d;
   logic [31:0] compare_q, compare_d;
   logic        pend_q,    pend_d;
   logic [15:0] presc_q,   presc_d;
   logic        ack_q,     ack_d;
   logic [31:0] data_q,    data_d;
   logic        irq_q,     irq_d;

   // ---------------------------------------------------------------------------
   // Decode helpers
   // ---------------------------------------------------------------------------
   logic        req;
   logic        bus_wr;
   logic        bus_rd;
   reg_addr_e   reg_addr;
   logic        tick;
   logic        count_wr;
   logic        pend_set;
   logic        pend_clr;
   logic [31:0] rd_value;

   // Address bits outside [3:2] are deliberately ignored.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{wb_addr_i[31:4], wb_addr_i[1:0]};

   // Replace only the byte lanes enabled in sel; keep the rest of old.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  sel);
      logic [31:0] result;
      result = old_val;
      for (int i = 0; i < 4; i++) begin
         if (sel[i]) begin
            result[8*i +: 8] = new_val[8*i +: 8];
         end
      end
      return result;
   endfunction

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      ctrl_d    = ctrl_q;
      count_d   = count_q;
      compare_d = compare_q;
      presc_d   = presc_q;
      tick      = 1'b0;
      pend_set  = 1'b0;
      pend_clr  = 1'b0;
      rd_value  = '0;

      // A request in the ack cycle is not a new request: this is what makes
      // held back-to-back requests complete every other cycle.
      req      = wb_cyc_i & wb_stb_i & ~ack_q;
      bus_wr   = req & wb_we_i;
      bus_rd   = req & ~wb_we_i;
      reg_addr = reg_addr_e'(wb_addr_i[3:2]);

      // A COUNT write with no lane enabled changes nothing, so it must not
      // swallow a tick either.
      count_wr = bus_wr && (reg_addr == REG_COUNT) && (wb_sel_i != 4'b0000);

      // Prescaler: free-runs 0..PRESCALE-1 while enabled, parked at 0 otherwise.
      if (ctrl_q[CTRL_EN]) begin
         if (presc_q == PRESCALE_MAX) begin
            presc_d = '0;
            tick    = 1'b1;
         end else begin
            presc_d = presc_q + 16'd1;
         end
      end else begin
         presc_d = '0;
      end

      // Counter step. The match uses compare_q, so a COMPARE write in the same
      // cycle only affects later ticks. A COUNT write in a tick cycle discards
      // the tick entirely.
      if (tick && !count_wr) begin
         if (count_q == compare_q) begin
            pend_set = 1'b1;
            count_d  = ctrl_q[CTRL_AUTO] ? 32'd0 : count_q + 32'd1;
         end else begin
            count_d  = count_q + 32'd1;
         end
      end

      // Bus writes.
      if (bus_wr) begin
         case (reg_addr)
            REG_CTRL: begin
               if (wb_sel_i[0]) begin
                  ctrl_d  = wb_data_i[2:0];
                  presc_d = '0;
               end
            end
            REG_COUNT: begin
               count_d = merge_bytes(count_q, wb_data_i, wb_sel_i);
            end
            REG_COMPARE: begin
               compare_d = merge_bytes(compare_q, wb_data_i, wb_sel_i);
            end
            REG_STATUS: begin
               pend_clr = wb_sel_i[0] & wb_data_i[0];
            end
            default: ;
         endcase
      end

      // A new match beats a clear arriving in the same cycle.
      pend_d = pend_set | (pend_q & ~pend_clr);

      // Read mux returns pre-edge register values (e.g. pre-tick COUNT).
      case (reg_addr)
         REG_CTRL:    rd_value = {29'd0, ctrl_q};
         REG_COUNT:   rd_value = count_q;
         REG_COMPARE: rd_value = compare_q;
         REG_STATUS:  rd_value = {31'd0, pend_q};
         default:     rd_value = '0;
      endcase

      ack_d  = req;
      data_d = bus_rd ? rd_value : 32'd0;
      irq_d  = pend_q & ctrl_q[CTRL_IE];
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only (synchronous), so rst
      // stays out of the sensitivity list.
      if (!rst) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // sees the pre-edge values of the others.
         ctrl_q    <= '0;
         count_q   <= '0;
         compare_q <= RESET_COMPARE;
         pend_q    <= 1'b0;
         presc_q   <= '0;
         ack_q     <= 1'b0;
         data_q    <= '0;
         irq_q     <= 1'b0;
      end else begin
         ctrl_q    <= ctrl_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
         presc_q   <= presc_d;
         ack_q     <= ack_d;
         data_q    <= data_d;
         irq_q     <= irq_d;
      end
   end

   assign wb_ack_o  = ack_q;
   assign wb_data_o = data_q;
   assign irq_o     = irq_q;

endmodule

// File: tb/tb_wb_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_wb_timer_slave
//
// Directed bench for wb_timer_slave. Two instances share one bus: u_p1 uses
// PRESCALE=1 and u_p4 uses PRESCALE=4; obs_p4 selects which one's outputs are
// observed. All inputs change 1 ns after a rising edge and outputs are
// sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_wb_timer_slave;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] wb_addr_i = '0;
   logic [31:0] wb_data_i = '0;
   logic        wb_we_i   = 1'b0;
   logic [3:0]  wb_sel_i  = '0;
   logic        wb_stb_i  = 1'b0;
   logic        wb_cyc_i  = 1'b0;

   logic [31:0] data_p1, data_p4;
   logic        ack_p1,  ack_p4;
   logic        irq_p1,  irq_p4;

   logic        obs_p4 = 1'b0;
   logic [31:0] data_m;
   logic        ack_m;
   logic        irq_m;

   int          errors = 0;
   int          checks = 0;
   logic        irq_at_ack;

   localparam logic [31:0] A_CTRL    = 32'h0000_0000;
   localparam logic [31:0] A_COUNT   = 32'h0000_0004;
   localparam logic [31:0] A_COMPARE = 32'h0000_0008;
   localparam logic [31:0] A_STATUS  = 32'h0000_000C;

   wb_timer_slave #(.PRESCALE(1), .RESET_COMPARE(32'hFFFF_FFFF)) u_p1 (
      .clk       (clk),
      .rst       (rst),
      .wb_addr_i (wb_addr_i),
      .wb_data_i (wb_data_i),
      .wb_data_o (data_p1),
      .wb_we_i   (wb_we_i),
      .wb_sel_i  (wb_sel_i),
      .wb_stb_i  (wb_stb_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_ack_o  (ack_p1),
      .irq_o     (irq_p1)
   );

   wb_timer_slave #(.PRESCALE(4), .RESET_COMPARE(32'hFFFF_FFFF)) u_p4 (
      .clk       (clk),
      .rst       (rst),
      .wb_addr_i (wb_addr_i),
      .wb_data_i (wb_data_i),
      .wb_data_o (data_p4),
      .wb_we_i   (wb_we_i),
      .wb_sel_i  (wb_sel_i),
      .wb_stb_i  (wb_stb_i),
      .wb_cyc_i  (wb_cyc_i),
      .wb_ack_o  (ack_p4),
      .irq_o     (irq_p4)
   );

   always #5 clk = ~clk;

   always_comb begin
      data_m = obs_p4 ? data_p4 : data_p1;
      ack_m  = obs_p4 ? ack_p4  : ack_p1;
      irq_m  = obs_p4 ? irq_p4  : irq_p1;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One bus transfer: request sampled at the next edge, ack expected right
   // after it, then ack and data must be back to 0 one cycle later.
   task automatic bus(input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] sel,
                      output logic [31:0] rdata);
      int lat;
      wb_cyc_i  = 1'b1;
      wb_stb_i  = 1'b1;
      wb_we_i   = we;
      wb_addr_i = addr;
      wb_data_i = wdata;
      wb_sel_i  = sel;
      lat       = 0;
      rdata     = '0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk);
         #1;
         if (ack_m) begin
            lat = i;
            break;
         end
      end
      rdata      = data_m;
      irq_at_ack = irq_m;
      wb_cyc_i   = 1'b0;
      wb_stb_i   = 1'b0;
      wb_we_i    = 1'b0;
      check("ack_latency", 32'(lat), 32'd1);
      @(posedge clk);
      #1;
      check("ack_drop", 32'(ack_m), 32'd0);
      check("data_drop", data_m, 32'd0);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sel);
      logic [31:0] unused_rdata;
      bus(1'b1, addr, wdata, sel, unused_rdata);
   endtask

   task automatic rd(input string tag, input logic [31:0] addr,
                     input logic [31:0] exp);
      logic [31:0] r;
      bus(1'b0, addr, 32'd0, 4'hF, r);
      check(tag, r, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- Reset ----------------
      rst = 1'b0;
      idle(3);
      check("rst_ack",  32'(ack_m), 32'd0);
      check("rst_data", data_m, 32'd0);
      check("rst_irq",  32'(irq_m), 32'd0);
      rst = 1'b1;
      rd("rst_ctrl",    A_CTRL,        32'd0);
      rd("rst_count",   A_COUNT,       32'd0);
      rd("rst_compare", 32'hABCD_0008, 32'hFFFF_FFFF);
      rd("rst_status",  A_STATUS,      32'd0);

      // ---------------- Byte lanes (counter disabled) ----------------
      wr(A_COUNT, 32'h1234_5678, 4'b0010);
      rd("lane1_only", A_COUNT, 32'h0000_5600);
      wr(A_COUNT, 32'h1234_5678, 4'b1111);
      rd("all_lanes", A_COUNT, 32'h1234_5678);
      wr(A_COUNT, 32'hDEAD_BEEF, 4'b0000);
      rd("sel_zero_no_change", A_COUNT, 32'h1234_5678);
      wr(A_CTRL, 32'hFFFF_FFF8, 4'b1111);
      rd("ctrl_upper_bits_zero", A_CTRL, 32'd0);

      // ---------------- PRESCALE=1, COMPARE=5, EN|AUTO|IE ----------------
      // CTRL write at edge W; ticks from W+1, match at W+6, irq after W+7.
      wr(A_COUNT, 32'd0, 4'hF);
      wr(A_COMPARE, 32'd5, 4'hF);
      wr(A_CTRL, 32'd7, 4'hF);
      rd("p1_count_w2", A_COUNT, 32'd1);
      rd("p1_count_w4", A_COUNT, 32'd3);
      check("p1_irq_before_match", 32'(irq_m), 32'd0);
      rd("p1_count_pretick_w6", A_COUNT, 32'd5);
      check("p1_irq_at_match_edge", 32'(irq_at_ack), 32'd0);
      check("p1_irq_one_after", 32'(irq_m), 32'd1);
      rd("p1_pend", A_STATUS, 32'd1);
      idle(1);
      rd("p1_auto_reload", A_COUNT, 32'd4);
      wr(A_CTRL, 32'd6, 4'hF);
      wr(A_STATUS, 32'd1, 4'b0001);
      check("p1_irq_still_high", 32'(irq_at_ack), 32'd1);
      check("p1_irq_cleared", 32'(irq_m), 32'd0);
      rd("p1_pend_cleared", A_STATUS, 32'd0);
      rd("p1_count_frozen", A_COUNT, 32'd1);

      // ---------------- PRESCALE=4, COMPARE=2, no AUTO ----------------
      // CTRL write at W; ticks at W+4, W+8, W+12 (match), W+16, W+20.
      obs_p4 = 1'b1;
      wr(A_STATUS, 32'd1, 4'b0001);
      wr(A_COUNT, 32'd0, 4'hF);
      wr(A_COMPARE, 32'd2, 4'hF);
      wr(A_CTRL, 32'd5, 4'hF);
      idle(10);
      rd("p4_pend_before_match", A_STATUS, 32'd0);
      check("p4_irq_at_match_edge", 32'(irq_at_ack), 32'd0);
      check("p4_irq_after_match", 32'(irq_m), 32'd1);
      rd("p4_pend_set", A_STATUS, 32'd1);
      rd("p4_count_continues3", A_COUNT, 32'd3);
      rd("p4_count_continues4", A_COUNT, 32'd4);
      rd("p4_pend_held", A_STATUS, 32'd1);

      // ---------------- Clear vs match, write vs tick (PRESCALE=4) -------
      // CTRL write at W; match tick at W+8, next tick at W+12.
      wr(A_CTRL, 32'd0, 4'hF);
      wr(A_STATUS, 32'd1, 4'b0001);
      wr(A_COUNT, 32'd0, 4'hF);
      wr(A_COMPARE, 32'd1, 4'hF);
      wr(A_CTRL, 32'd5, 4'hF);
      idle(6);
      wr(A_STATUS, 32'd1, 4'b0001);
      rd("set_beats_clear", A_STATUS, 32'd1);
      wr(A_COUNT, 32'd100, 4'hF);
      rd("write_beats_tick", A_COUNT, 32'd100);

      // ---------------- Wrap without match (PRESCALE=1) ----------------
      obs_p4 = 1'b0;
      wr(A_CTRL, 32'd0, 4'hF);
      wr(A_STATUS, 32'd1, 4'b0001);
      wr(A_COUNT, 32'hFFFF_FFFF, 4'hF);
      wr(A_COMPARE, 32'd10, 4'hF);
      wr(A_CTRL, 32'd1, 4'hF);
      rd("wrap_to_zero", A_COUNT, 32'd0);
      rd("wrap_no_pend", A_STATUS, 32'd0);
      rd("ctrl_before_reset", A_CTRL, 32'd1);

      // ---------------- Reset during a pending read ----------------
      wb_cyc_i  = 1'b1;
      wb_stb_i  = 1'b1;
      wb_we_i   = 1'b0;
      wb_addr_i = A_CTRL;
      wb_sel_i  = 4'hF;
      rst       = 1'b0;
      idle(1);
      check("rst_cancels_ack", 32'(ack_m), 32'd0);
      check("rst_cancels_data", data_m, 32'd0);
      check("rst_irq_low", 32'(irq_m), 32'd0);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      rst      = 1'b1;
      rd("post_rst_ctrl",    A_CTRL,    32'd0);
      rd("post_rst_count",   A_COUNT,   32'd0);
      rd("post_rst_compare", A_COMPARE, 32'hFFFF_FFFF);
      rd("post_rst_status",  A_STATUS,  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
